// File: rtl/mem_port_arbiter_if.sv
// Line-port bundle shared by icache, dcache and memory.
// The arbiter takes the slave side; clients and memory drive the master side.
interface mem_port_arbiter_if #(
  parameter int LINE_BITS = 256
);
  logic                 i_read;
  logic [31:0]          i_addr;
  logic [LINE_BITS-1:0] i_rdata;
  logic                 i_resp;
  logic                 d_read;
  logic                 d_write;
  logic [31:0]          d_addr;
  logic [LINE_BITS-1:0] d_wdata;
  logic [LINE_BITS-1:0] d_rdata;
  logic                 d_resp;
  logic                 m_read;
  logic                 m_write;
  logic [31:0]          m_addr;
  logic [LINE_BITS-1:0] m_wdata;
  logic [LINE_BITS-1:0] m_rdata;
  logic                 m_resp;

  modport slave (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  m_rdata, m_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output m_read, m_write, m_addr, m_wdata
  );

  modport master (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output m_rdata, m_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Non-pipelined I/D arbiter for the single memory line port.
// D has priority; a starvation counter bounds how long fetch waits.
module mem_port_arbiter #(
  parameter int LINE_BITS    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int OFF = $clog2(LINE_BITS / 8);
  localparam logic [CW-1:0] LIM   = CW'(STARVE_LIMIT);
  localparam logic [31:0]   AMASK = ~((32'd1 << OFF) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT_I,
    S_GRANT_D,
    S_RESP_I,
    S_RESP_D
  } state_t;

  state_t               r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic                 r_mread, w_mread_n;
  logic                 r_mwrite, w_mwrite_n;
  logic [31:0]          r_maddr, w_maddr_n;
  logic [LINE_BITS-1:0] r_mwdata, w_mwdata_n;
  logic                 r_iresp, w_iresp_n;
  logic                 r_dresp, w_dresp_n;
  logic [LINE_BITS-1:0] r_irdata, w_irdata_n;
  logic [LINE_BITS-1:0] r_drdata, w_drdata_n;

  logic w_dreq;
  logic w_force_i;
  logic w_d_win;

  assign w_dreq    = bus.d_read | bus.d_write;
  assign w_force_i = bus.i_read && (STARVE_LIMIT != 0) && (r_cnt == LIM);
  assign w_d_win   = w_dreq & ~w_force_i;

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_mread_n  = r_mread;
    w_mwrite_n = r_mwrite;
    w_maddr_n  = r_maddr;
    w_mwdata_n = r_mwdata;
    w_iresp_n  = 1'b0;
    w_dresp_n  = 1'b0;
    w_irdata_n = r_irdata;
    w_drdata_n = r_drdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_d_win) begin
          // simultaneous read+write is a write-back
          w_state_n  = S_GRANT_D;
          w_mwrite_n = bus.d_write;
          w_mread_n  = ~bus.d_write;
          w_maddr_n  = bus.d_addr & AMASK;
          w_mwdata_n = bus.d_write ? bus.d_wdata : '0;
          if (!bus.i_read)
            w_cnt_n = '0;
          else if (r_cnt != LIM)
            w_cnt_n = r_cnt + 1'b1;
        end else if (bus.i_read) begin
          w_state_n  = S_GRANT_I;
          w_mread_n  = 1'b1;
          w_mwrite_n = 1'b0;
          w_maddr_n  = bus.i_addr & AMASK;
          w_mwdata_n = '0;
          w_cnt_n    = '0;
        end
      end
      S_GRANT_I: begin
        if (bus.m_resp) begin
          w_state_n  = S_RESP_I;
          w_iresp_n  = 1'b1;
          w_mread_n  = 1'b0;
          w_mwrite_n = 1'b0;
          w_maddr_n  = '0;
          w_mwdata_n = '0;
          w_irdata_n = bus.m_rdata;
        end
      end
      S_GRANT_D: begin
        if (bus.m_resp) begin
          w_state_n  = S_RESP_D;
          w_dresp_n  = 1'b1;
          w_mread_n  = 1'b0;
          w_mwrite_n = 1'b0;
          w_maddr_n  = '0;
          w_mwdata_n = '0;
          if (r_mread)
            w_drdata_n = bus.m_rdata;
        end
      end
      S_RESP_I, S_RESP_D: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mread  <= 1'b0;
      r_mwrite <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_iresp  <= 1'b0;
      r_dresp  <= 1'b0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_mread  <= w_mread_n;
      r_mwrite <= w_mwrite_n;
      r_maddr  <= w_maddr_n;
      r_mwdata <= w_mwdata_n;
      r_iresp  <= w_iresp_n;
      r_dresp  <= w_dresp_n;
      r_irdata <= w_irdata_n;
      r_drdata <= w_drdata_n;
    end
  end

  assign bus.m_read  = r_mread;
  assign bus.m_write = r_mwrite;
  assign bus.m_addr  = r_maddr;
  assign bus.m_wdata = r_mwdata;
  assign bus.i_resp  = r_iresp;
  assign bus.d_resp  = r_dresp;
  assign bus.i_rdata = r_irdata;
  assign bus.d_rdata = r_drdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter.
// Reference model works at transaction level from the arbitration rules.
module tb_mem_port_arbiter;
  localparam int LB = 256;
  localparam int SL = 2;
  localparam logic [31:0] AM = 32'hFFFF_FFE0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.LINE_BITS(LB)) b();
  mem_port_arbiter_if #(.LINE_BITS(LB)) b0();

  mem_port_arbiter #(.LINE_BITS(LB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  mem_port_arbiter #(.LINE_BITS(LB), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic c32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cl(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LB-1:0] rnd();
    logic [LB-1:0] r;
    for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Wait for a strobe, keep it for lat cycles, then answer with rd.
  // Returns at the response-pulse cycle.
  task automatic mem_txn(input int lat, input logic [LB-1:0] rd,
                         output logic mr, output logic mw,
                         output logic [31:0] ad, output logic [LB-1:0] wd);
    int n;
    n = 0;
    while (!(b.m_read || b.m_write) && n < 40) begin
      tick();
      n++;
    end
    c1("txn_timeout", n < 40, 1'b1);
    c1("txn_excl", b.m_read & b.m_write, 1'b0);
    mr = b.m_read;
    mw = b.m_write;
    ad = b.m_addr;
    wd = b.m_wdata;
    for (int j = 0; j < lat; j++) begin
      tick();
      c1("txn_hold", b.m_read | b.m_write, 1'b1);
    end
    b.m_resp = 1'b1;
    b.m_rdata = rd;
    tick();
    b.m_resp = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mr, mw;
    logic [31:0] ad;
    logic [LB-1:0] wd, rd, last_dr, la;
    logic [31:0] ia, da;
    int phase, streak, lat_left, icnt, dcnt;
    logic cur_d, e_mr, e_mw, e_ir_p, e_dr_p, t_mw;
    logic [31:0] t_ma;
    logic [LB-1:0] t_wd, e_ir, e_dr;

    {b.i_read, b.d_read, b.d_write, b.m_resp} = '0;
    b.i_addr = '0; b.d_addr = '0; b.d_wdata = '0; b.m_rdata = '0;
    {b0.i_read, b0.d_read, b0.d_write, b0.m_resp} = '0;
    b0.i_addr = '0; b0.d_addr = '0; b0.d_wdata = '0; b0.m_rdata = '0;
    rst = 1'b1;
    tick();
    tick();
    c1("rst_mread", b.m_read, 1'b0);
    c1("rst_mwrite", b.m_write, 1'b0);
    c32("rst_maddr", b.m_addr, 32'h0);
    c1("rst_iresp", b.i_resp, 1'b0);
    c1("rst_dresp", b.d_resp, 1'b0);
    cl("rst_irdata", b.i_rdata, '0);
    cl("rst_drdata", b.d_rdata, '0);

    // 1: I-only read, memory answers at cycle 3
    rst = 1'b0;
    b.i_read = 1'b1;
    b.i_addr = 32'h0000_0064;
    la = rnd();
    for (int c = 1; c <= 3; c++) begin
      tick();
      c1("t1_mread", b.m_read, 1'b1);
      c32("t1_maddr", b.m_addr, 32'h0000_0060);
      c1("t1_iresp_early", b.i_resp, 1'b0);
    end
    b.m_resp = 1'b1;
    b.m_rdata = la;
    tick();
    b.m_resp = 1'b0;
    b.i_read = 1'b0;
    c1("t1_iresp", b.i_resp, 1'b1);
    cl("t1_irdata", b.i_rdata, la);
    c1("t1_mread_resp", b.m_read, 1'b0);
    c1("t1_dresp", b.d_resp, 1'b0);
    tick();
    c1("t1_iresp_one", b.i_resp, 1'b0);

    // 2: simultaneous I and D, D first
    ia = 32'h0000_2345;
    da = 32'h0000_8888;
    b.i_read = 1'b1; b.i_addr = ia;
    b.d_read = 1'b1; b.d_addr = da;
    rd = rnd();
    mem_txn(1, rd, mr, mw, ad, wd);
    c32("t2_daddr", ad, da & AM);
    c1("t2_dresp", b.d_resp, 1'b1);
    c1("t2_iresp", b.i_resp, 1'b0);
    c1("t2_mread_resp", b.m_read, 1'b0);
    cl("t2_drdata", b.d_rdata, rd);
    b.d_read = 1'b0;
    tick();
    c1("t2_mread_idle", b.m_read, 1'b0);
    rd = rnd();
    mem_txn(0, rd, mr, mw, ad, wd);
    c32("t2_iaddr", ad, ia & AM);
    c1("t2_iresp2", b.i_resp, 1'b1);
    cl("t2_irdata", b.i_rdata, rd);
    b.i_read = 1'b0;
    tick();

    // 3: starvation, both held: D D I D D I
    ia = 32'h0000_1040;
    da = 32'h0000_3F20;
    b.i_read = 1'b1; b.i_addr = ia;
    b.d_read = 1'b1; b.d_addr = da;
    for (int k = 0; k < 6; k++) begin
      rd = rnd();
      mem_txn(0, rd, mr, mw, ad, wd);
      c32("t3_order", ad, (k % 3 == 2) ? (ia & AM) : (da & AM));
      if (k % 3 != 2) last_dr = rd;
    end
    b.i_read = 1'b0;
    b.d_read = 1'b0;
    tick();

    // 4: write-back leaves d_rdata alone
    b.d_write = 1'b1;
    b.d_addr = 32'h1004_0013;
    la = rnd();
    b.d_wdata = la;
    mem_txn(1, rnd(), mr, mw, ad, wd);
    c1("t4_mwrite", mw, 1'b1);
    c1("t4_mread", mr, 1'b0);
    c32("t4_maddr", ad, 32'h1004_0000);
    cl("t4_mwdata", wd, la);
    c1("t4_dresp", b.d_resp, 1'b1);
    cl("t4_drdata", b.d_rdata, last_dr);
    b.d_write = 1'b0;
    tick();
    c1("t4_dresp_one", b.d_resp, 1'b0);

    // 5: read+write together is a write
    b.d_read = 1'b1;
    b.d_write = 1'b1;
    b.d_addr = 32'h0000_0400;
    mem_txn(2, rnd(), mr, mw, ad, wd);
    c1("t5_mwrite", mw, 1'b1);
    c1("t5_mread", mr, 1'b0);
    cl("t5_drdata", b.d_rdata, last_dr);
    b.d_read = 1'b0;
    b.d_write = 1'b0;
    tick();

    // 6: reset during GRANT_I, late m_resp ignored
    b.i_read = 1'b1;
    b.i_addr = 32'h0000_7000;
    tick();
    c1("t6_mread", b.m_read, 1'b1);
    rst = 1'b1;
    tick();
    c1("t6_rst_mread", b.m_read, 1'b0);
    c32("t6_rst_maddr", b.m_addr, 32'h0);
    cl("t6_rst_irdata", b.i_rdata, '0);
    cl("t6_rst_drdata", b.d_rdata, '0);
    rst = 1'b0;
    b.i_read = 1'b0;
    tick();
    b.m_resp = 1'b1;
    b.m_rdata = rnd();
    tick();
    b.m_resp = 1'b0;
    c1("t6_late_iresp", b.i_resp, 1'b0);
    cl("t6_late_irdata", b.i_rdata, '0);
    b.i_read = 1'b1;
    rd = rnd();
    mem_txn(2, rd, mr, mw, ad, wd);
    c32("t6_maddr", ad, 32'h0000_7000);
    c1("t6_iresp", b.i_resp, 1'b1);
    cl("t6_irdata", b.i_rdata, rd);
    b.i_read = 1'b0;
    tick();

    // randomized traffic against the transaction-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    phase = 0; streak = 0; lat_left = 0;
    cur_d = 1'b0; t_mw = 1'b0; t_ma = '0; t_wd = '0;
    e_mr = 1'b0; e_mw = 1'b0; e_ir_p = 1'b0; e_dr_p = 1'b0;
    e_ir = '0; e_dr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      c1("r_mread", b.m_read, e_mr);
      c1("r_mwrite", b.m_write, e_mw);
      if (e_mr | e_mw) begin
        c32("r_maddr", b.m_addr, t_ma);
        cl("r_mwdata", b.m_wdata, t_wd);
      end
      c1("r_iresp", b.i_resp, e_ir_p);
      c1("r_dresp", b.d_resp, e_dr_p);
      cl("r_irdata", b.i_rdata, e_ir);
      cl("r_drdata", b.d_rdata, e_dr);

      if (b.i_resp) b.i_read = 1'b0;
      if (b.d_resp) begin
        b.d_read = 1'b0;
        b.d_write = 1'b0;
      end
      if (!b.i_read && $urandom_range(0, 2) == 0) begin
        b.i_read = 1'b1;
        b.i_addr = $urandom;
      end
      if (!(b.d_read | b.d_write) && $urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: b.d_read = 1'b1;
          2: b.d_write = 1'b1;
          default: begin b.d_read = 1'b1; b.d_write = 1'b1; end
        endcase
        b.d_addr = $urandom;
        b.d_wdata = rnd();
      end

      b.m_resp = 1'b0;
      b.m_rdata = rnd();
      if (phase == 1) begin
        if (lat_left == 0) b.m_resp = 1'b1;
        else lat_left--;
      end else if ($urandom_range(0, 5) == 0) begin
        b.m_resp = 1'b1;
      end

      e_ir_p = 1'b0;
      e_dr_p = 1'b0;
      if (phase == 0) begin
        if (b.i_read || b.d_read || b.d_write) begin
          cur_d = (b.d_read || b.d_write) && !(b.i_read && SL != 0 && streak == SL);
          if (cur_d) begin
            streak = b.i_read ? ((streak < SL) ? streak + 1 : streak) : 0;
            t_mw = b.d_write;
            t_ma = b.d_addr & AM;
            t_wd = b.d_write ? b.d_wdata : '0;
          end else begin
            streak = 0;
            t_mw = 1'b0;
            t_ma = b.i_addr & AM;
            t_wd = '0;
          end
          e_mr = !t_mw;
          e_mw = t_mw;
          phase = 1;
          lat_left = $urandom_range(0, 3);
        end
      end else if (phase == 1) begin
        if (b.m_resp) begin
          e_mr = 1'b0;
          e_mw = 1'b0;
          phase = 2;
          if (cur_d) e_dr_p = 1'b1;
          else e_ir_p = 1'b1;
          if (!t_mw) begin
            if (cur_d) e_dr = b.m_rdata;
            else e_ir = b.m_rdata;
          end
        end
      end else begin
        phase = 0;
      end
      tick();
    end
    b.i_read = 1'b0; b.d_read = 1'b0; b.d_write = 1'b0; b.m_resp = 1'b0;

    // strict D priority: fetch never served under continuous D traffic
    b0.i_read = 1'b1; b0.i_addr = 32'h0000_0100;
    b0.d_read = 1'b1; b0.d_addr = 32'h0000_0200;
    icnt = 0;
    dcnt = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (b0.i_resp) icnt++;
      if (b0.d_resp) dcnt++;
      b0.m_rdata = rnd();
      b0.m_resp = (b0.m_read | b0.m_write) & ~b0.m_resp;
    end
    c32("sl0_iresp_cnt", 32'(icnt), 32'd0);
    c1("sl0_d_progress", dcnt >= 15, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
